// File: rtl/surf4_pps_pkg.sv
// surf4_pps_pkg: mode and FSM encodings plus counter sizing shared by the PPS generator.
package surf4_pps_pkg;

    typedef enum logic [1:0] {
        PPS_MODE_EXT  = 2'b00,
        PPS_MODE_INT  = 2'b01,
        PPS_MODE_HOLD = 2'b10,
        PPS_MODE_SW   = 2'b11
    } pps_mode_t;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'b00,
        ST_LOCKED   = 2'b01,
        ST_HOLDOVER = 2'b10
    } pps_state_t;

    function automatic int cnt_width(input int freq, input int tol);
        return $clog2(freq + tol + 1);
    endfunction

endpackage

// File: rtl/surf4_pps_if.sv
// surf4_pps_if: PPS pin, mode select, software strobe and the conditioned PPS/status outputs.
interface surf4_pps_if;

    logic        PPS;
    logic [1:0]  sel_i;
    logic        sw_pps_i;
    logic        pps_o;
    logic        locked_o;
    logic        holdover_o;
    logic        pps_missing_o;
    logic [31:0] period_o;
    logic        period_valid_o;

    modport master (
        output PPS, sel_i, sw_pps_i,
        input  pps_o, locked_o, holdover_o, pps_missing_o, period_o, period_valid_o
    );

    modport slave (
        input  PPS, sel_i, sw_pps_i,
        output pps_o, locked_o, holdover_o, pps_missing_o, period_o, period_valid_o
    );

endinterface

// File: rtl/surf4_pps_filter.sv
// surf4_pps_filter: synchronises the raw PPS pin and emits one qual_edge per sufficiently long high run.
module surf4_pps_filter #(
    parameter int SYNC_STAGES     = 2,
    parameter int MIN_HIGH_CYCLES = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_pps,
    output logic o_qual_edge
);

    localparam int RW = $clog2(MIN_HIGH_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [RW-1:0]          r_run;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= '0;
            r_run  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pps};
            // Saturating at the threshold keeps a long high run from firing twice.
            r_run  <= !w_synced ? '0 : (r_run == RW'(MIN_HIGH_CYCLES)) ? r_run : r_run + RW'(1);
        end
    end

    assign o_qual_edge = w_synced && (r_run == RW'(MIN_HIGH_CYCLES - 1));

endmodule

// File: rtl/surf4_pps_gen.sv
// surf4_pps_gen: PPS conditioning, period measurement, lock/holdover tracking and PPS synthesis.
module surf4_pps_gen
    import surf4_pps_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = 100000000,
    parameter int PERIOD_TOL      = 1000,
    parameter int SYNC_STAGES     = 2,
    parameter int MIN_HIGH_CYCLES = 8
) (
    input logic        clk_i,
    input logic        rst_i,
    surf4_pps_if.slave io
);

    localparam int CW = cnt_width(CLK_FREQ_HZ, PERIOD_TOL);

    logic          w_qual, w_sel_chg, w_good, w_itick, w_win, w_timeout;
    logic          w_realign, w_missing, w_pps;
    logic [31:0]   r_pcnt, r_period;
    logic [CW-1:0] r_icnt;
    logic [1:0]    r_sel;
    logic          r_seen, r_valid, r_pps, r_missing, r_locked, r_hold;
    pps_state_t    r_state, w_next;

    surf4_pps_filter #(
        .SYNC_STAGES    (SYNC_STAGES),
        .MIN_HIGH_CYCLES(MIN_HIGH_CYCLES)
    ) u_filter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_pps      (io.PPS),
        .o_qual_edge(w_qual)
    );

    assign w_sel_chg = io.sel_i != r_sel;
    // A period only counts once an earlier edge has started the measurement.
    assign w_good    = r_seen && r_pcnt >= 32'(CLK_FREQ_HZ - PERIOD_TOL) && r_pcnt <= 32'(CLK_FREQ_HZ + PERIOD_TOL);
    assign w_itick   = r_icnt == CW'(CLK_FREQ_HZ - 1);
    assign w_win     = r_icnt <= CW'(PERIOD_TOL) || r_icnt >= CW'(CLK_FREQ_HZ - 1 - PERIOD_TOL);
    assign w_timeout = r_pcnt == 32'(CLK_FREQ_HZ + PERIOD_TOL);

    always_comb begin
        w_next    = r_state;
        w_realign = 1'b0;
        w_missing = 1'b0;
        case (r_state)
            ST_UNLOCKED: begin
                w_next    = (w_qual && w_good) ? ST_LOCKED : ST_UNLOCKED;
                w_realign = w_qual && w_good;
            end
            ST_LOCKED: begin
                w_next    = w_qual ? (w_good ? ST_LOCKED : ST_UNLOCKED) : w_timeout ? ST_HOLDOVER : ST_LOCKED;
                w_realign = w_qual ? w_good : w_timeout;
                w_missing = !w_qual && w_timeout;
            end
            ST_HOLDOVER: begin
                w_next    = w_qual ? (w_win ? ST_LOCKED : ST_UNLOCKED) : ST_HOLDOVER;
                w_realign = w_qual && w_win;
            end
            default: w_next = ST_UNLOCKED;
        endcase
        if (w_sel_chg) begin
            w_next    = ST_UNLOCKED;
            w_missing = 1'b0;
        end
        w_pps = w_sel_chg ? 1'b0 :
                io.sel_i == PPS_MODE_EXT ? w_qual :
                io.sel_i == PPS_MODE_INT ? w_itick :
                io.sel_i == PPS_MODE_SW  ? io.sw_pps_i :
                r_state == ST_HOLDOVER   ? (w_qual | w_itick) : (w_qual | w_missing);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_UNLOCKED;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pcnt    <= '0;
            r_period  <= '0;
            r_icnt    <= '0;
            r_sel     <= '0;
            r_seen    <= 1'b0;
            r_valid   <= 1'b0;
            r_pps     <= 1'b0;
            r_missing <= 1'b0;
            r_locked  <= 1'b0;
            r_hold    <= 1'b0;
        end else begin
            r_pcnt    <= w_qual ? 32'd1 : (&r_pcnt) ? r_pcnt : r_pcnt + 32'd1;
            r_period  <= w_qual ? r_pcnt : r_period;
            // Free-run mode never realigns the internal second to external events.
            r_icnt    <= (w_sel_chg || (w_realign && io.sel_i != PPS_MODE_INT) || w_itick) ? '0 : r_icnt + CW'(1);
            r_sel     <= io.sel_i;
            r_seen    <= !w_sel_chg && (r_seen || w_qual);
            r_valid   <= !w_sel_chg && (r_valid || (w_qual && r_seen));
            r_pps     <= w_pps;
            r_missing <= w_missing;
            r_locked  <= w_next == ST_LOCKED;
            r_hold    <= w_next == ST_HOLDOVER;
        end
    end

    assign io.pps_o          = r_pps;
    assign io.locked_o       = r_locked;
    assign io.holdover_o     = r_hold;
    assign io.pps_missing_o  = r_missing;
    assign io.period_o       = r_period;
    assign io.period_valid_o = r_valid;

endmodule
